// File: rtl/oled_sink_pkg.sv
// Shared constants and types for the OLED SPI receive model.
// Holds the SSD1306 addressing opcodes and the command-parser state encoding.
package oled_sink_pkg;

    localparam logic [7:0] CMD_COL_ADDR  = 8'h21;
    localparam logic [7:0] CMD_PAGE_ADDR = 8'h22;

    typedef enum logic [2:0] {
        IDLE,
        COL_S,
        COL_E,
        PAGE_S,
        PAGE_E
    } parser_state_t;

endpackage

// File: rtl/spi_rx_byte.sv
// SPI mode-0 byte receiver oversampled on the system clock.
// Synchronises the pins, detects sck rising edges and assembles MSB-first bytes.
module spi_rx_byte (
    input  logic       clk,
    input  logic       rst,
    input  logic       sck,
    input  logic       mosi,
    input  logic       ss_n,
    input  logic       dc,
    output logic       byte_valid,
    output logic [7:0] rx_byte,
    output logic       dc_at_byte
);

    logic [1:0] sck_sync;
    logic [1:0] mosi_sync;
    logic [1:0] ss_sync;
    logic [1:0] dc_sync;
    logic       sck_hist;

    // Edge-detect stage: the rise pulse and the data bits it qualifies travel together.
    logic       rise_q;
    logic       mosi_q;
    logic       dc_q;

    logic [7:0] shift_reg;
    logic [2:0] bit_cnt;
    logic [7:0] next_shift;

    assign next_shift = {shift_reg[6:0], mosi_q};

    // NOTE: every register here uses <= so all stages sample the previous cycle's values.
    always_ff @(posedge clk) begin
        if (rst) begin
            sck_sync   <= 2'b00;
            mosi_sync  <= 2'b00;
            ss_sync    <= 2'b11;
            dc_sync    <= 2'b00;
            sck_hist   <= 1'b0;
            rise_q     <= 1'b0;
            mosi_q     <= 1'b0;
            dc_q       <= 1'b0;
            shift_reg  <= 8'h00;
            bit_cnt    <= 3'd0;
            byte_valid <= 1'b0;
            rx_byte    <= 8'h00;
            dc_at_byte <= 1'b0;
        end else begin
            sck_sync  <= {sck_sync[0], sck};
            mosi_sync <= {mosi_sync[0], mosi};
            ss_sync   <= {ss_sync[0], ss_n};
            dc_sync   <= {dc_sync[0], dc};
            sck_hist  <= sck_sync[1];

            rise_q <= sck_sync[1] & ~sck_hist & ~ss_sync[1];
            mosi_q <= mosi_sync[1];
            dc_q   <= dc_sync[1];

            byte_valid <= 1'b0;
            if (rise_q) begin
                shift_reg <= next_shift;
                bit_cnt   <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                    byte_valid <= 1'b1;
                    rx_byte    <= next_shift;
                    dc_at_byte <= dc_q;
                end
            end

            // A release seen alongside the final edge still lets that byte complete above.
            if (ss_sync[1]) begin
                bit_cnt   <= 3'd0;
                shift_reg <= 8'h00;
            end
        end
    end

endmodule

// File: rtl/oled_spi_sink.sv
// Device end of the OLED SPI link: parses SSD1306 column/page window commands
// and turns data bytes into framebuffer write strobes in horizontal addressing order.
module oled_spi_sink
    import oled_sink_pkg::*;
#(
    parameter int COL_BITS  = 7,
    parameter int PAGE_BITS = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          sck,
    input  logic                          mosi,
    input  logic                          ss_n,
    input  logic                          dc,
    output logic                          cmd_valid,
    output logic [7:0]                    cmd_byte,
    output logic                          fb_we,
    output logic [PAGE_BITS+COL_BITS-1:0] fb_addr,
    output logic [7:0]                    fb_data,
    output logic                          frame_done
);

    logic       byte_valid;
    logic [7:0] rx_byte;
    logic       dc_at_byte;

    spi_rx_byte u_rx (
        .clk        (clk),
        .rst        (rst),
        .sck        (sck),
        .mosi       (mosi),
        .ss_n       (ss_n),
        .dc         (dc),
        .byte_valid (byte_valid),
        .rx_byte    (rx_byte),
        .dc_at_byte (dc_at_byte)
    );

    parser_state_t state_q;
    parser_state_t state_d;

    logic [COL_BITS-1:0]  col_start;
    logic [COL_BITS-1:0]  col_end;
    logic [PAGE_BITS-1:0] page_start;
    logic [PAGE_BITS-1:0] page_end;
    logic [COL_BITS-1:0]  col;
    logic [PAGE_BITS-1:0] page;

    logic [COL_BITS-1:0]  arg_col;
    logic [PAGE_BITS-1:0] arg_page;

    assign arg_col  = rx_byte[COL_BITS-1:0];
    assign arg_page = rx_byte[PAGE_BITS-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Any data byte abandons a half-received window command.
    always_comb begin
        state_d = state_q;
        if (byte_valid) begin
            if (dc_at_byte) begin
                state_d = IDLE;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        if (rx_byte == CMD_COL_ADDR) begin
                            state_d = COL_S;
                        end else if (rx_byte == CMD_PAGE_ADDR) begin
                            state_d = PAGE_S;
                        end
                    end
                    COL_S:   state_d = COL_E;
                    COL_E:   state_d = IDLE;
                    PAGE_S:  state_d = PAGE_E;
                    PAGE_E:  state_d = IDLE;
                    default: state_d = IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_start  <= '0;
            col_end    <= '1;
            page_start <= '0;
            page_end   <= '1;
            col        <= '0;
            page       <= '0;
            cmd_valid  <= 1'b0;
            cmd_byte   <= 8'h00;
            fb_we      <= 1'b0;
            fb_addr    <= '0;
            fb_data    <= 8'h00;
            frame_done <= 1'b0;
        end else begin
            cmd_valid  <= 1'b0;
            fb_we      <= 1'b0;
            frame_done <= 1'b0;

            if (byte_valid && dc_at_byte) begin
                fb_we   <= 1'b1;
                fb_addr <= {page, col};
                fb_data <= rx_byte;
                if (col == col_end) begin
                    col <= col_start;
                    if (page == page_end) begin
                        page       <= page_start;
                        frame_done <= 1'b1;
                    end else begin
                        page <= page + PAGE_BITS'(1);
                    end
                end else begin
                    col <= col + COL_BITS'(1);
                end
            end

            if (byte_valid && !dc_at_byte) begin
                cmd_valid <= 1'b1;
                cmd_byte  <= rx_byte;
                unique case (state_q)
                    COL_S: begin
                        col_start <= arg_col;
                        col       <= arg_col;
                    end
                    COL_E:  col_end <= arg_col;
                    PAGE_S: begin
                        page_start <= arg_page;
                        page       <= arg_page;
                    end
                    PAGE_E: page_end <= arg_page;
                    default: ;
                endcase
            end
        end
    end

endmodule
